// File: rtl/cpu_core.sv
// cpu_core: single-cycle 4-bit register-file CPU.
// One 32-bit instruction is consumed per clock. Decode and ALU are purely
// combinational. The register file, the status register and cpu_output
// update together on the rising edge whenever a writing opcode targets a
// register other than r0.
// Tensor opcodes (05/06) are recognised but do nothing here, because the
// tensor unit is a separate block.
module cpu_core #(
    parameter int NUM_REGS   = 256,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic [31:0]           current_instruction,
    output logic [DATA_WIDTH-1:0] cpu_output
);

    localparam logic [7:0] OP_ADD     = 8'h00;
    localparam logic [7:0] OP_SUB     = 8'h01;
    localparam logic [7:0] OP_EQL     = 8'h03;
    localparam logic [7:0] OP_GRT     = 8'h04;
    localparam logic [7:0] OP_ADD_IMM = 8'h09;
    localparam logic [7:0] OP_SUB_IMM = 8'h0A;

    localparam int MSB = DATA_WIDTH - 1;

    // Flat register file. Register n lives at [(NUM_REGS-1-n)*DATA_WIDTH +: DATA_WIDTH],
    // which places r0 at the MSBs. r0 is never written, so it always reads 0.
    logic [NUM_REGS*DATA_WIDTH-1:0] registers;

    // Status register bit order: [4]=P [3]=O [2]=C [1]=Z [0]=S.
    logic [4:0]                     status_register;

    // Instruction fields.
    logic [7:0]            w_rd;
    logic [7:0]            w_rs1;
    logic [7:0]            w_rs2;
    logic [7:0]            w_opcode;
    logic [DATA_WIDTH-1:0] w_imm;

    // Register reads, taken before the edge, so rd == rs1 == rs2 behaves correctly.
    logic [DATA_WIDTH-1:0] w_reg_view [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH-1:0] w_b_op;

    // ALU outputs.
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  alu_carry_flag;
    logic                  alu_overflow_flag;
    logic                  alu_zero_flag;
    logic                  alu_sign_flag;
    logic                  alu_parity_flag;
    logic                  cpu_register_file_write_enable;
    logic                  w_commit;

    assign w_rd     = current_instruction[31:24];
    assign w_rs1    = current_instruction[23:16];
    assign w_rs2    = current_instruction[15:8];
    assign w_opcode = current_instruction[7:0];
    assign w_imm    = current_instruction[8 +: DATA_WIDTH];

    // Array view of the flat register file, so that operand reads are simple indexes.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_view
            assign w_reg_view[gi] = registers[(NUM_REGS-1-gi)*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_a    = w_reg_view[w_rs1];
    assign w_b    = w_reg_view[w_rs2];
    assign w_b_op = (w_opcode == OP_ADD_IMM || w_opcode == OP_SUB_IMM) ? w_imm : w_b;

    // The extra top bit of the sum holds the carry-out. The extra top bit of the
    // difference holds the borrow, which is set exactly when a < b unsigned.
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b_op};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b_op};

    // Combinational ALU: selects the result, the carry/overflow flags and the write enable.
    always_comb begin
        w_result                       = '0;
        alu_carry_flag                 = 1'b0;
        alu_overflow_flag              = 1'b0;
        cpu_register_file_write_enable = 1'b0;
        case (w_opcode)
            OP_ADD, OP_ADD_IMM: begin
                w_result                       = w_sum[MSB:0];
                alu_carry_flag                 = w_sum[DATA_WIDTH];
                alu_overflow_flag              = (w_a[MSB] == w_b_op[MSB]) &&
                                                 (w_sum[MSB] != w_a[MSB]);
                cpu_register_file_write_enable = 1'b1;
            end
            OP_SUB, OP_SUB_IMM: begin
                w_result                       = w_diff[MSB:0];
                alu_carry_flag                 = w_diff[DATA_WIDTH];
                alu_overflow_flag              = (w_a[MSB] != w_b_op[MSB]) &&
                                                 (w_diff[MSB] != w_a[MSB]);
                cpu_register_file_write_enable = 1'b1;
            end
            OP_EQL: begin
                w_result                       = (w_a == w_b) ? DATA_WIDTH'(1) : '0;
                cpu_register_file_write_enable = 1'b1;
            end
            OP_GRT: begin
                w_result                       = ($signed(w_a) > $signed(w_b)) ? DATA_WIDTH'(1) : '0;
                cpu_register_file_write_enable = 1'b1;
            end
            default: begin
                // NOP, the tensor opcodes and every unknown opcode leave all state untouched.
                w_result                       = '0;
            end
        endcase
    end

    assign alu_zero_flag   = (w_result == '0);
    assign alu_sign_flag   = w_result[MSB];
    assign alu_parity_flag = ^w_result;

    // A write aimed at r0 is discarded entirely. This is what lets instruction 0
    // (ADD r0,r0,r0) have no visible effect.
    assign w_commit = cpu_register_file_write_enable && (w_rd != 8'd0);

    // Register file, status and output update together. Reset takes priority over any instruction.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            registers       <= '0;
            status_register <= '0;
            cpu_output      <= '0;
        end else if (w_commit) begin
            registers[(NUM_REGS - 1 - int'(w_rd))*DATA_WIDTH +: DATA_WIDTH] <= w_result;
            status_register <= {alu_parity_flag, alu_overflow_flag, alu_carry_flag,
                                alu_zero_flag, alu_sign_flag};
            cpu_output      <= w_result;
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Testbench for cpu_core.
// Directed instruction vectors with hand-computed expectations. Each issued
// instruction pushes its expected outcome into a queue. A monitor pops one
// entry after every rising edge and compares it against the DUT.
module tb_cpu_core;

    logic        clock_in;
    logic        reset_in;
    logic [31:0] current_instruction;
    logic [3:0]  cpu_output;

    int errors = 0;
    int checks = 0;

    cpu_core dut (
        .clock_in            (clock_in),
        .reset_in            (reset_in),
        .current_instruction (current_instruction),
        .cpu_output          (cpu_output)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        string      name;
        bit         chk_os;   // compare cpu_output and status
        logic [3:0] out;
        logic [4:0] st;
        int         rd;       // register to inspect
        logic [3:0] rv;       // expected value of that register
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2, input int op);
        return {rd[7:0], rs1[7:0], rs2[7:0], op[7:0]};
    endfunction

    function automatic logic [3:0] reg_of(input int n);
        return dut.registers[(255-n)*4 +: 4];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one instruction at the falling edge, then queue what the next rising edge must produce.
    task automatic issue(input string name, input logic [31:0] instr, input bit chk_os,
                         input logic [3:0] out, input logic [4:0] st,
                         input int rd, input logic [3:0] rv);
        exp_t e;
        @(negedge clock_in);
        current_instruction = instr;
        e.name = name; e.chk_os = chk_os; e.out = out; e.st = st; e.rd = rd; e.rv = rv;
        sb.push_back(e);
        $display("issue %-14s instr=%08h", name, instr);
    endtask

    // Monitor: consume one expectation per rising edge, sampled 1ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock_in);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_os) begin
                    check({e.name, ".out"}, 32'(cpu_output), 32'(e.out));
                    check({e.name, ".status"}, 32'(dut.status_register), 32'(e.st));
                end
                check({e.name, ".reg"}, 32'(reg_of(e.rd)), 32'(e.rv));
                $display("check %-14s out=%0h status=%05b r%0d=%0h", e.name, cpu_output,
                         dut.status_register, e.rd, reg_of(e.rd));
            end
        end
    end

    // Opcodes
    localparam int ADD = 8'h00, SUB = 8'h01, EQL = 8'h03, GRT = 8'h04;
    localparam int ADDI = 8'h09, SUBI = 8'h0A, NOP = 8'h08;

    initial begin
        int wait_cycles;
        reset_in            = 1'b1;
        current_instruction = 32'h0;
        repeat (2) @(posedge clock_in);
        @(negedge clock_in);
        reset_in = 1'b0;
        #1;
        check("reset.out", 32'(cpu_output), 32'h0);
        check("reset.status", 32'(dut.status_register), 32'h0);
        check("reset.regs", 32'(dut.registers != '0), 32'h0);

        // Basic arithmetic: carry out of bit 3.
        issue("addi_r1",  mk(1, 0, 5, ADDI),    1, 4'd5,  5'b00000, 1,  4'd5);
        issue("addi_r2",  mk(2, 1, 10, ADDI),   1, 4'd15, 5'b00001, 2,  4'd15);
        issue("add_r3",   mk(3, 1, 2, ADD),     1, 4'd4,  5'b10100, 3,  4'd4);
        // Signed overflow.
        issue("addi_r20", mk(20, 0, 7, ADDI),   1, 4'd7,  5'b10000, 20, 4'd7);
        issue("addi_r21", mk(21, 20, 1, ADDI),  1, 4'd8,  5'b11001, 21, 4'd8);
        issue("add_r23",  mk(23, 21, 21, ADD),  1, 4'd0,  5'b01110, 23, 4'd0);
        // Subtraction and borrow.
        issue("subi_r25", mk(25, 0, 1, SUBI),   1, 4'd15, 5'b00101, 25, 4'd15);
        issue("sub_r4",   mk(4, 2, 1, SUB),     1, 4'd10, 5'b00001, 4,  4'd10);
        // Zero and parity flags.
        issue("addi_r26", mk(26, 0, 0, ADDI),   1, 4'd0,  5'b00010, 26, 4'd0);
        issue("addi_r29", mk(29, 0, 3, ADDI),   1, 4'd3,  5'b00000, 29, 4'd3);
        issue("addi_r30", mk(30, 0, 7, ADDI),   1, 4'd7,  5'b10000, 30, 4'd7);
        // Compare ops.
        issue("eql_r7",   mk(7, 3, 3, EQL),     1, 4'd1,  5'b10000, 7,  4'd1);
        issue("grt_r8",   mk(8, 6, 2, GRT),     1, 4'd1,  5'b10000, 8,  4'd1);
        issue("grt_r9",   mk(9, 2, 1, GRT),     1, 4'd0,  5'b00010, 9,  4'd0);
        issue("eql_r10",  mk(10, 1, 2, EQL),    1, 4'd0,  5'b00010, 10, 4'd0);
        issue("addi_r11", mk(11, 0, 6, ADDI),   1, 4'd6,  5'b00000, 11, 4'd6);
        // NOP-class opcodes: nothing changes.
        issue("nop_08",   mk(12, 1, 2, NOP),    1, 4'd6,  5'b00000, 12, 4'd0);
        issue("tensor_05", mk(12, 1, 2, 8'h05), 1, 4'd6,  5'b00000, 12, 4'd0);
        issue("tensor_06", mk(12, 1, 2, 8'h06), 1, 4'd6,  5'b00000, 12, 4'd0);
        issue("op_ff",    mk(12, 1, 2, 8'hFF),  1, 4'd6,  5'b00000, 12, 4'd0);
        // Writes to r0 are ignored.
        issue("addi_r0",  mk(0, 0, 5, ADDI),    0, 4'd0,  5'b00000, 0,  4'd0);
        issue("addi_r13", mk(13, 0, 2, ADDI),   1, 4'd2,  5'b10000, 13, 4'd2);
        // rd == rs1 == rs2, operands read before the edge.
        issue("add_r13",  mk(13, 13, 13, ADD),  1, 4'd4,  5'b10000, 13, 4'd4);
        @(negedge clock_in);
        current_instruction = 32'h0;

        // Drain the scoreboard, with a bounded wait.
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(posedge clock_in);
            #2;
            wait_cycles++;
        end
        check("drain", 32'(sb.size()), 32'h0);
        sb.delete();

        // Asynchronous reset asserted between edges.
        @(negedge clock_in);
        #2;
        reset_in = 1'b1;
        #1;
        check("async_rst.out", 32'(cpu_output), 32'h0);
        check("async_rst.status", 32'(dut.status_register), 32'h0);
        check("async_rst.regs", 32'(dut.registers != '0), 32'h0);
        // An instruction present while reset is held has no effect.
        current_instruction = mk(9, 0, 3, ADDI);
        @(posedge clock_in);
        #1;
        check("rst_hold.r9", 32'(reg_of(9)), 32'h0);
        check("rst_hold.out", 32'(cpu_output), 32'h0);
        @(negedge clock_in);
        current_instruction = 32'h0;
        reset_in = 1'b0;

        // After reset, r1 starts from 0 again.
        issue("post_rst_r1", mk(1, 1, 1, ADDI), 1, 4'd1, 5'b10000, 1, 4'd1);
        @(negedge clock_in);
        current_instruction = 32'h0;
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(posedge clock_in);
            #2;
            wait_cycles++;
        end
        check("drain_final", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
